// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, decoder-bundle bit positions and the ID/EX register-update policy.
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 10;
    localparam int CNT_W  = 16;

    localparam int CTRL_BRANCH   = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_ALU_LSB  = 6;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        UPD_FLUSH,
        UPD_BUBBLE,
        UPD_HOLD,
        UPD_LOAD
    } upd_e;

    function automatic upd_e next_upd(input logic flush, input logic hz, input logic ex_ready);
        return flush ? UPD_FLUSH : hz ? UPD_BUBBLE : !ex_ready ? UPD_HOLD : UPD_LOAD;
    endfunction
endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: load-use detection and the PC / IF-ID stall request.
// Detection is built only when ID_EX_HAZARD_DETECT_EN is defined; otherwise hz is tied low.
module hazard_unit
    import riscv_pkg::*;
(
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              hz,
    output logic              stall
);
`ifdef ID_EX_HAZARD_DETECT_EN
    // x0 never carries a loaded value, so it can never create a dependency
    assign hz = ex_valid & ex_memread & id_valid & (ex_rd != '0) &
                ((ex_rd == id_rs1) | (ex_rd == id_rs2));
`else
    logic unused_hz_inputs;
    assign unused_hz_inputs = ^{ex_valid, ex_memread, ex_rd, id_valid, id_rs1, id_rs2};
    assign hz = 1'b0;
`endif
    assign stall = (hz | ~ex_ready) & ~flush;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with flush, load-use bubble, hold and a saturating bubble counter.
// Optional load-use detection: define ID_EX_HAZARD_DETECT_EN.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic hz;
    upd_e upd;

    hazard_unit u_hazard (
        .ex_valid   (ex_valid),
        .ex_memread (ex_ctrl[CTRL_MEMREAD]),
        .ex_rd      (ex_rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .hz         (hz),
        .stall      (stall)
    );

    assign upd = next_upd(flush, hz, ex_ready);

    // Flush and bubble only kill valid/ctrl; data fields are left as-is since nothing consumes them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else begin
            case (upd)
                UPD_FLUSH, UPD_BUBBLE: begin
                    ex_valid <= 1'b0;
                    ex_ctrl  <= '0;
                end
                UPD_LOAD: begin
                    ex_valid    <= id_valid;
                    ex_ctrl     <= id_valid ? id_ctrl : '0;
                    ex_pc       <= id_pc;
                    ex_rs1_data <= id_rs1_data;
                    ex_rs2_data <= id_rs2_data;
                    ex_imm      <= id_imm;
                    ex_rs1      <= id_rs1;
                    ex_rs2      <= id_rs2;
                    ex_rd       <= id_rd;
                end
                default: ;
            endcase
        end
    end

`ifdef ID_EX_HAZARD_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= '0;
        else if (upd == UPD_BUBBLE && bubble_cnt != CNT_MAX)
            bubble_cnt <= bubble_cnt + 1'b1;
    end
`else
    assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus hand-written multi-cycle sequences for id_ex_stage.
module tb_id_ex_stage;
    import riscv_pkg::*;

`ifdef ID_EX_HAZARD_DETECT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    localparam logic [9:0] ADD = 10'h0A0;
    localparam logic [9:0] LW  = 10'h0BC;
    localparam logic [9:0] SW  = 10'h08A;
    localparam logic [9:0] BEQ = 10'h181;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [9:0]  id_ctrl = '0;
    logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;
    logic        ex_valid, stall;
    logic [9:0]  ex_ctrl;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [15:0] bubble_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic        v;
        logic [9:0]  c;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] pc;
        logic        fl, rdy;
        logic        st, ev;
        logic [9:0]  ec;
        logic        dc;
        logic [4:0]  erd, ers1, ers2;
        logic [31:0] epc;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Data operands are derived from pc so one pc column pins every data field
    task automatic drive(input logic v, input logic [9:0] c, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] pc,
                         input logic fl, input logic rdy);
        id_valid = v; id_ctrl = c; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_pc = pc;
        id_rs1_data = pc ^ 32'hA5A5_0000; id_rs2_data = pc ^ 32'h0000_5A5A; id_imm = ~pc;
        flush = fl; ex_ready = rdy;
    endtask

    task automatic chk_ex(input string tag, input logic ev, input logic [9:0] ec,
                          input logic [4:0] erd, input logic [31:0] epc);
        chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, ev});
        chk({tag, ".ex_ctrl"}, {22'd0, ex_ctrl}, {22'd0, ec});
        chk({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, erd});
        chk({tag, ".ex_pc"}, ex_pc, epc);
    endtask

    initial begin
        tv[0]  = '{1, ADD, 5, 1, 2, 32'h100, 0, 1,  0, 1, ADD, 1, 5, 1, 2, 32'h100};
        tv[1]  = '{1, SW,  0, 3, 4, 32'h104, 0, 1,  0, 1, SW,  1, 0, 3, 4, 32'h104};
        tv[2]  = '{0, ADD, 7, 5, 6, 32'h108, 0, 1,  0, 0, 0,   1, 7, 5, 6, 32'h108};
        tv[3]  = '{1, BEQ, 0, 1, 2, 32'h10C, 1, 1,  0, 0, 0,   0, 0, 0, 0, 32'h0};
        tv[4]  = '{1, LW,  6, 2, 0, 32'h110, 0, 1,  0, 1, LW,  1, 6, 2, 0, 32'h110};
        tv[5]  = '{1, ADD, 9, 7, 8, 32'h114, 0, 1,  0, 1, ADD, 1, 9, 7, 8, 32'h114};
        tv[6]  = '{1, ADD, 3, 9, 9, 32'h118, 0, 0,  1, 1, ADD, 1, 9, 7, 8, 32'h114};
        tv[7]  = '{1, ADD, 3, 9, 9, 32'h118, 0, 1,  0, 1, ADD, 1, 3, 9, 9, 32'h118};
        tv[8]  = '{1, LW,  0, 1, 0, 32'h11C, 0, 1,  0, 1, LW,  1, 0, 1, 0, 32'h11C};
        tv[9]  = '{1, ADD, 4, 0, 0, 32'h120, 0, 1,  0, 1, ADD, 1, 4, 0, 0, 32'h120};
        tv[10] = '{1, LW,  8, 1, 2, 32'h124, 0, 1,  0, 1, LW,  1, 8, 1, 2, 32'h124};
        tv[11] = '{1, ADD, 10, 8, 3, 32'h128, 1, 1, 0, 0, 0,   0, 0, 0, 0, 32'h0};
        tv[12] = '{1, ADD, 10, 8, 3, 32'h128, 0, 1, 0, 1, ADD, 1, 10, 8, 3, 32'h128};

        #1 rst_n = 1'b0;
        #2;
        chk_ex("reset", 0, 0, 0, 0);
        chk("reset.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("reset.stall", {31'd0, stall}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tv[i].v, tv[i].c, tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].pc, tv[i].fl, tv[i].rdy);
            #1 chk($sformatf("v%0d.stall", i), {31'd0, stall}, {31'd0, tv[i].st});
            @(posedge clk); #1;
            chk($sformatf("v%0d.ex_valid", i), {31'd0, ex_valid}, {31'd0, tv[i].ev});
            chk($sformatf("v%0d.ex_ctrl", i), {22'd0, ex_ctrl}, {22'd0, tv[i].ec});
            chk($sformatf("v%0d.bubble_cnt", i), {16'd0, bubble_cnt}, 32'd0);
            if (tv[i].dc) begin
                chk($sformatf("v%0d.ex_rd", i), {27'd0, ex_rd}, {27'd0, tv[i].erd});
                chk($sformatf("v%0d.ex_rs1", i), {27'd0, ex_rs1}, {27'd0, tv[i].ers1});
                chk($sformatf("v%0d.ex_rs2", i), {27'd0, ex_rs2}, {27'd0, tv[i].ers2});
                chk($sformatf("v%0d.ex_pc", i), ex_pc, tv[i].epc);
                chk($sformatf("v%0d.ex_rs1_data", i), ex_rs1_data, tv[i].epc ^ 32'hA5A5_0000);
                chk($sformatf("v%0d.ex_rs2_data", i), ex_rs2_data, tv[i].epc ^ 32'h0000_5A5A);
                chk($sformatf("v%0d.ex_imm", i), ex_imm, ~tv[i].epc);
            end
        end

        // load-use: lw x6 then add x7,x6,x2
        @(negedge clk) drive(1, LW, 6, 1, 0, 32'h200, 0, 1);
        @(posedge clk); #1 chk_ex("lu.lw", 1, LW, 6, 32'h200);
        @(negedge clk) drive(1, ADD, 7, 6, 2, 32'h204, 0, 1);
        #1 chk("lu.stall1", {31'd0, stall}, {31'd0, HZ});
        @(posedge clk); #1;
        chk_ex("lu.bubble", !HZ, HZ ? 10'h0 : ADD, HZ ? 5'd6 : 5'd7, HZ ? 32'h200 : 32'h204);
        chk("lu.cnt1", {16'd0, bubble_cnt}, {31'd0, HZ});
        @(negedge clk); #1 chk("lu.stall2", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk_ex("lu.add", 1, ADD, 7, 32'h204);
        chk("lu.cnt2", {16'd0, bubble_cnt}, {31'd0, HZ});

        // hold for three cycles, load on the fourth edge
        @(negedge clk) drive(1, ADD, 10, 1, 2, 32'h300, 0, 1);
        @(posedge clk);
        @(negedge clk) drive(1, SW, 11, 3, 4, 32'h304, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("hold%0d.stall", k), {31'd0, stall}, 32'd1);
            @(posedge clk); #1 chk_ex($sformatf("hold%0d", k), 1, ADD, 10, 32'h300);
            @(negedge clk);
        end
        ex_ready = 1'b1;
        #1 chk("hold.release.stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1 chk_ex("hold.load", 1, SW, 11, 32'h304);

        // async reset between edges while a load-use stall is pending
        @(negedge clk) drive(1, LW, 6, 1, 0, 32'h400, 0, 1);
        @(posedge clk);
        @(negedge clk) drive(1, ADD, 7, 6, 2, 32'h404, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_ex("arst", 0, 0, 0, 0);
        chk("arst.ex_imm", ex_imm, 32'd0);
        chk("arst.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("arst.stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1 chk_ex("arst.held", 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        drive(1, ADD, 12, 1, 2, 32'h500, 0, 1);
        @(posedge clk); #1 chk_ex("arst.first_load", 1, ADD, 12, 32'h500);

        // saturation: preset near the top, then keep a self-dependent lw in ID
`ifdef ID_EX_HAZARD_DETECT_EN
        @(negedge clk) force dut.bubble_cnt = 16'hFFFC;
        #1 release dut.bubble_cnt;
`endif
        @(negedge clk) drive(1, LW, 6, 6, 0, 32'h600, 0, 1);
        repeat (12) @(posedge clk);
        #1 chk("sat.bubble_cnt", {16'd0, bubble_cnt}, HZ ? 32'h0000_FFFF : 32'd0);
        @(negedge clk) drive(0, 10'h0, 0, 0, 0, 32'h0, 1, 1);
        @(posedge clk); #1 chk("sat.flush_keeps", {16'd0, bubble_cnt}, HZ ? 32'h0000_FFFF : 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_valid  in  1  the ID stage holds a real instruction.
REQ-005 id_ctrl  in  10  decoder bundle {alu_control[3:0], regwrite, memtoreg, alusrc, memread, memwrite, branch} (bit 9 down to bit 0).
REQ-006 id_pc, id_rs1_data, id_rs2_data, id_imm  in  32 each  ID-stage operands.
REQ-007 id_rs1, id_rs2, id_rd  in  5 each  register addresses.
REQ-008 flush  in  1  branch/jump redirect; kill the instruction entering EX.
REQ-009 ex_ready  in  1  EX can accept a new instruction this cycle.
REQ-010 ex_valid, ex_ctrl[9:0], ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd  out  registered copies of the ID inputs.
REQ-011 stall  out  1  combinational; hold PC and IF/ID when high.
REQ-012 bubble_cnt  out  16  saturating count of inserted bubbles.

Function
REQ-013 The register update priority per rising edge SHALL be: flush > hazard bubble > hold (ex_ready=0) > load.
REQ-014 Flush: ex_valid<=0 and ex_ctrl<=0; data fields are don't-care.
REQ-015 Load-use hazard: hz = ex_valid & ex_ctrl[2] (memread) & id_valid & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-016 Hazard bubble: when hz=1 and flush=0, ex_valid<=0 and ex_ctrl<=0 while the ID inputs stay unconsumed.
REQ-017 Hold: when ex_ready=0, hz=0 and flush=0, all ex_* registers SHALL keep their values.
REQ-018 Load: otherwise, ex_valid<=id_valid and all fields SHALL be copied from id_*; ex_ctrl<=0 when id_valid=0.
REQ-019 stall = (hz | ~ex_ready) & ~flush.
REQ-020 A load-use stall SHALL last exactly one cycle, since the bubble clears memread.
REQ-021 A bubble at ex_rd=0 SHALL never occur (x0 is exempt).
REQ-022 bubble_cnt SHALL increment by 1 on each hazard bubble, saturate at 16'hFFFF, and not count flushes.
REQ-023 Latency: ID to EX is 1 cycle with no stalls.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously set ex_valid=0, ex_ctrl=0, all data/address outputs=0 and bubble_cnt=0.
REQ-025 Reset asserted mid-stall SHALL discard the pending instruction.
REQ-026 stall SHALL be 0 after reset, provided ex_ready=1.
REQ-027 The first load SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro ID_EX_HAZARD_DETECT_EN, when defined, SHALL enable load-use detection per REQ-015/016/022.
REQ-029 When ID_EX_HAZARD_DETECT_EN is undefined, hz SHALL be 0, bubble_cnt SHALL be tied to 0, and stall = ~ex_ready & ~flush.

Structure
REQ-030 Package riscv_pkg SHALL hold the ctrl bit-index constants (CTRL_MEMREAD=2, etc.), CTRL_W=10, XLEN=32 and REG_AW=5.
REQ-031 Sub-module hazard_unit SHALL contain the combinational hz/stall logic.
REQ-032 id_ex_stage SHALL contain the pipeline registers and the counter.

Verification
REQ-033 Plain R-type: add with id_ctrl=10'h... (regwrite=1), rd=5 -> next cycle ex_valid=1, ex_rd=5, ex_ctrl equals input, stall=0.
REQ-034 Load-use: lw x6 in EX (memread=1, ex_rd=6), then add with rs1=6 in ID -> stall=1 for one cycle, a bubble (ex_valid=0, ex_ctrl=0) follows, add enters EX on the next cycle, bubble_cnt=1.
REQ-035 x0 case: lw with ex_rd=0 and ID rs2=0 -> stall=0, no bubble.
REQ-036 Flush and hazard together: flush=1 with hz=1 -> stall=0, ex_valid=0, bubble_cnt unchanged.
REQ-037 Hold: ex_ready=0 for 3 cycles with a new ID instruction -> ex_* unchanged and stall=1 for 3 cycles, then load on the 4th edge.
REQ-038 Async reset mid-operation: rst_n=0 between clock edges -> all outputs 0 immediately; 65540 forced hazards saturate bubble_cnt at 16'hFFFF.
